// File: rtl/drop_test_board_pkg.sv
// Shared definitions for the two-phone drop test board.
//   DEF_FLOOR_W : default width of floor / resistance inputs
//   DEF_CNT_W   : default width of the result counters
//   state_t     : drop-test FSM states
package drop_test_board_pkg;

    localparam int DEF_FLOOR_W = 7;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_COARSE,
        ST_FINE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/drop_test_board_step_calc.sv
// step_size_calc: finds the smallest s >= 1 with s(s+1)/2 >= n, one
// increment of s per enabled cycle.
//   clk, rst_n : clock, async active-low reset
//   clear      : reload s = 1, tri = 1
//   enable     : advance the search while not yet valid
//   n          : target floor count (held stable while enabled)
//   s          : current candidate step size
//   valid      : s satisfies s(s+1)/2 >= n
module step_size_calc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] n,
    output logic [W-1:0] s,
    output logic         valid
);

    // One extra bit so the triangular number cannot wrap before reaching n.
    logic [W:0] tri_q;
    logic [W-1:0] s_q;

    assign s     = s_q;
    assign valid = (tri_q >= {1'b0, n});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= W'(1);
            tri_q <= (W + 1)'(1);
        end else if (clear) begin
            s_q   <= W'(1);
            tri_q <= (W + 1)'(1);
        end else if (enable && !valid) begin
            // T(s+1) = T(s) + s + 1
            s_q   <= s_q + W'(1);
            tri_q <= tri_q + {1'b0, s_q} + (W + 1)'(1);
        end
    end

endmodule

// File: rtl/drop_test_board_top.sv
// Two-phone drop test: given building height N and hidden resistance R,
// locates the highest safe floor with the optimal two-phone strategy and
// reports drop statistics.
//   in_clk, in_rst         : clock, async active-low reset
//   in_floors_data         : building height N
//   in_resistance_data     : resistance R (floor f breaks iff f > R)
//   result_attempt_count   : total drops
//   result_broken_count    : drops that broke a phone
//   result_is_last_broken  : final drop broke a phone
//   result_done            : test finished, results held until reset
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | capture N and R on the first clock after reset release
// ST_STEP   | search for step size s; N = 0 finishes immediately
// ST_COARSE | drop at s, s+(s-1), ... clamped to N, until break or N
// ST_FINE   | drop lo+1, lo+2, ... up to hi-1 with the second phone
// ST_DONE   | results frozen until reset
module drop_test_board_top
    import drop_test_board_pkg::*;
#(
    parameter int FLOOR_W = DEF_FLOOR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [FLOOR_W-1:0] in_floors_data,
    input  logic [FLOOR_W-1:0] in_resistance_data,
    output logic [CNT_W-1:0]   result_attempt_count,
    output logic [CNT_W-1:0]   result_broken_count,
    output logic               result_is_last_broken,
    output logic               result_done
);

    // One extra bit so floor + step cannot wrap before the clamp to N.
    localparam int FW = FLOOR_W + 1;

    state_t state_q, state_d;
    logic [FW-1:0] n_q, n_d, r_q, r_d;
    logic [FW-1:0] floor_q, floor_d, step_q, step_d, lo_q, lo_d, hi_q, hi_d;
    logic [CNT_W-1:0] att_q, att_d, brk_q, brk_d;
    logic last_q, last_d, done_q, done_d;

    logic [FW-1:0] s;
    logic s_valid, calc_clear, calc_en;
    logic [FW-1:0] coarse_sum;

    assign calc_clear = (state_q == ST_IDLE);
    assign calc_en    = (state_q == ST_STEP);

    step_size_calc #(.W(FW)) u_step_calc (
        .clk    (in_clk),
        .rst_n  (in_rst),
        .clear  (calc_clear),
        .enable (calc_en),
        .n      (n_q),
        .s      (s),
        .valid  (s_valid)
    );

    assign coarse_sum = floor_q + step_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        r_d     = r_q;
        floor_d = floor_q;
        step_d  = step_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        att_d   = att_q;
        brk_d   = brk_q;
        last_d  = last_q;
        done_d  = done_q;

        unique case (state_q)
            ST_IDLE: begin
                n_d     = {1'b0, in_floors_data};
                r_d     = {1'b0, in_resistance_data};
                state_d = ST_STEP;
            end
            ST_STEP: begin
                if (n_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (s_valid) begin
                    floor_d = (s > n_q) ? n_q : s;
                    step_d  = (s > FW'(1)) ? s - FW'(1) : FW'(1);
                    lo_d    = '0;
                    state_d = ST_COARSE;
                end
            end
            ST_COARSE: begin
                att_d = att_q + CNT_W'(1);
                if (floor_q > r_q) begin
                    brk_d = brk_q + CNT_W'(1);
                    hi_d  = floor_q;
                    if (lo_q + FW'(1) == floor_q) begin
                        // Nothing left between last safe floor and the break.
                        last_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        floor_d = lo_q + FW'(1);
                        state_d = ST_FINE;
                    end
                end else if (floor_q == n_q) begin
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    lo_d    = floor_q;
                    floor_d = (coarse_sum > n_q) ? n_q : coarse_sum;
                    step_d  = (step_q > FW'(1)) ? step_q - FW'(1) : FW'(1);
                end
            end
            ST_FINE: begin
                att_d = att_q + CNT_W'(1);
                if (floor_q > r_q) begin
                    brk_d   = brk_q + CNT_W'(1);
                    last_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (floor_q == hi_q - FW'(1)) begin
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    floor_d = floor_q + FW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            r_q     <= '0;
            floor_q <= '0;
            step_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            att_q   <= '0;
            brk_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            r_q     <= r_d;
            floor_q <= floor_d;
            step_q  <= step_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            att_q   <= att_d;
            brk_q   <= brk_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign result_attempt_count  = att_q;
    assign result_broken_count   = brk_q;
    assign result_is_last_broken = last_q;
    assign result_done           = done_q;

endmodule

// File: tb/tb_drop_test_board_top.sv
module tb_drop_test_board_top;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic [6:0]  in_floors_data = '0;
    logic [6:0]  in_resistance_data = '0;
    logic [31:0] result_attempt_count;
    logic [31:0] result_broken_count;
    logic        result_is_last_broken;
    logic        result_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 in_clk = ~in_clk;

    drop_test_board_top dut (
        .in_clk                (in_clk),
        .in_rst                (in_rst),
        .in_floors_data        (in_floors_data),
        .in_resistance_data    (in_resistance_data),
        .result_attempt_count  (result_attempt_count),
        .result_broken_count   (result_broken_count),
        .result_is_last_broken (result_is_last_broken),
        .result_done           (result_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!result_done && cycles < budget) begin
            @(posedge in_clk);
            #1;
            cycles++;
        end
    endtask

    task automatic run_case(input string tag, input int n, input int r,
                            input int ea, input int eb, input int el, output int cycles);
        @(negedge in_clk);
        in_rst             = 1'b0;
        in_floors_data     = 7'(n);
        in_resistance_data = 7'(r);
        #1;
        check({tag, "_rst_att"}, result_attempt_count, 0);
        check({tag, "_rst_done"}, {31'd0, result_done}, 0);
        @(negedge in_clk);
        in_rst = 1'b1;
        wait_done(80, cycles);
        check({tag, "_done"}, {31'd0, result_done}, 1);
        check({tag, "_att"}, result_attempt_count, 32'(ea));
        check({tag, "_brk"}, result_broken_count, 32'(eb));
        check({tag, "_last"}, {31'd0, result_is_last_broken}, 32'(el));
        // inputs changed after capture must not disturb the held result
        @(negedge in_clk);
        in_floors_data     = 7'd99;
        in_resistance_data = 7'd1;
        repeat (5) @(posedge in_clk);
        #1;
        check({tag, "_hold_att"}, result_attempt_count, 32'(ea));
        check({tag, "_hold_done"}, {31'd0, result_done}, 1);
    endtask

    initial begin
        #12;
        check("por_att", result_attempt_count, 0);
        check("por_brk", result_broken_count, 0);
        check("por_last", {31'd0, result_is_last_broken}, 0);
        check("por_done", {31'd0, result_done}, 0);

        run_case("n40r20", 40, 20, 7, 2, 1, cyc);
        run_case("n10r6",  10, 6,  4, 1, 0, cyc);
        run_case("n20r9",  20, 9,  6, 2, 1, cyc);
        run_case("n40r3",  40, 3,  5, 2, 1, cyc);
        run_case("n10r15", 10, 15, 4, 0, 0, cyc);
        run_case("n0",     0,  5,  0, 0, 0, cyc);
        run_case("n1r0",   1,  0,  1, 1, 1, cyc);
        run_case("n1r5",   1,  5,  1, 0, 0, cyc);
        // floors 16,31,45,58,70,81,91,100,108,115,121,126,127(break)
        run_case("n127r126", 127, 126, 13, 1, 1, cyc);
        check("n127_under40", {31'd0, (cyc < 40)}, 1);

        // reset in the middle of the coarse phase
        @(negedge in_clk);
        in_rst             = 1'b0;
        in_floors_data     = 7'd40;
        in_resistance_data = 7'd20;
        @(negedge in_clk);
        in_rst = 1'b1;
        repeat (12) @(posedge in_clk);
        #1;
        check("mid_running", {31'd0, (result_attempt_count != 0)}, 1);
        check("mid_notdone", {31'd0, result_done}, 0);
        @(negedge in_clk);
        in_rst             = 1'b0;
        in_floors_data     = 7'd10;
        in_resistance_data = 7'd5;
        #1;
        check("mid_clr_att", result_attempt_count, 0);
        check("mid_clr_brk", result_broken_count, 0);
        @(negedge in_clk);
        in_rst = 1'b1;
        wait_done(80, cyc);
        check("mid_done", {31'd0, result_done}, 1);
        check("mid_att", result_attempt_count, 4);
        check("mid_brk", result_broken_count, 2);
        check("mid_last", {31'd0, result_is_last_broken}, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
